keypad_scanner: RTL

//  Parametrised matrix keypad scanner for the vending-machine front panel. Drives columns
//  one at a time, samples rows, and debounces whole-matrix scan frames.

---
 rtl/keypad_pkg.sv | 13 +
 rtl/keypad_scanner_if.sv | 25 ++
 rtl/keypad_frame_debounce.sv | 68 ++++++
 rtl/keypad_scanner.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and helpers for the matrix keypad scanner.
// State and frame-result encodings plus a width helper safe for tiny sizes.
package keypad_pkg;

  typedef enum logic [1:0] {IDLE, PRESSED, BLOCKED} state_t;
  typedef enum logic [1:0] {NONE, SINGLE, MULTI} kind_t;

  // Never return 0 so degenerate sizes still get a 1-bit vector.
  function automatic int code_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Pin-side and controller-side signals of the keypad scanner.
// The master modport is the scanner itself; slave is the consumer view.
interface keypad_scanner_if #(
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int CODE_W = 4
);
  logic [ROWS-1:0]   row;
  logic [COLS-1:0]   shift_col;
  logic [CODE_W-1:0] key_code;
  logic              key_valid;
  logic              key_held;
  logic              key_release;
  logic              multi_key;

  modport master (
    input  row,
    output shift_col, key_code, key_valid, key_held, key_release, multi_key
  );

  modport slave (
    output row,
    input  shift_col, key_code, key_valid, key_held, key_release, multi_key
  );
endinterface

// File: rtl/keypad_frame_debounce.sv
// Frame-level debounce: a frame result must repeat DEBOUNCE times in a row
// before it is reported as stable; the strobe fires once per stable frame.
module keypad_frame_debounce
  import keypad_pkg::*;
#(
  parameter int CODE_W   = 4,
  parameter int DEBOUNCE = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_end,
  input  kind_t             res_kind,
  input  logic [CODE_W-1:0] res_code,
  output kind_t             stable_kind,
  output logic [CODE_W-1:0] stable_code,
  output logic              stable_strobe
);
  localparam int CNT_W = code_w(DEBOUNCE + 1);

  kind_t             cand_kind_reg, cand_kind_next;
  logic [CODE_W-1:0] cand_code_reg, cand_code_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  kind_t             stable_kind_reg;
  logic [CODE_W-1:0] stable_code_reg;
  logic              strobe_reg, strobe_next;

  always_comb begin
    cand_kind_next = cand_kind_reg;
    cand_code_next = cand_code_reg;
    cnt_next       = cnt_reg;
    if (frame_end) begin
      // Non-SINGLE results carry code 0, so a full compare is exact.
      if (res_kind == cand_kind_reg && res_code == cand_code_reg) begin
        if (cnt_reg != CNT_W'(DEBOUNCE))
          cnt_next = cnt_reg + 1'b1;
      end else begin
        cand_kind_next = res_kind;
        cand_code_next = res_code;
        cnt_next       = CNT_W'(1);
      end
    end
    strobe_next = frame_end && (cnt_next == CNT_W'(DEBOUNCE));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cand_kind_reg   <= NONE;
      cand_code_reg   <= '0;
      cnt_reg         <= '0;
      stable_kind_reg <= NONE;
      stable_code_reg <= '0;
      strobe_reg      <= 1'b0;
    end else begin
      cand_kind_reg <= cand_kind_next;
      cand_code_reg <= cand_code_next;
      cnt_reg       <= cnt_next;
      strobe_reg    <= strobe_next;
      if (strobe_next) begin
        stable_kind_reg <= cand_kind_next;
        stable_code_reg <= cand_code_next;
      end
    end
  end

  assign stable_kind   = stable_kind_reg;
  assign stable_code   = stable_code_reg;
  assign stable_strobe = strobe_reg;
endmodule

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: row synchroniser, column walker, frame collector,
// frame debounce and the press/release/lockout FSM.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int ROWS     = 4,
  parameter int COLS     = 4,
  parameter int SCAN_DIV = 4,
  parameter int DEBOUNCE = 3
) (
  input logic            clk,
  input logic            reset,
  keypad_scanner_if.master bus
);
  localparam int CODE_W = code_w(ROWS * COLS);
  localparam int ROW_W  = code_w(ROWS);
  localparam int COL_W  = code_w(COLS);
  localparam int DW_W   = code_w(SCAN_DIV);

  logic [ROWS-1:0]   row_meta_reg, row_sync_reg;
  logic [DW_W-1:0]   dwell_reg;
  logic [COL_W-1:0]  col_idx_reg;
  logic [1:0]        hits_reg;
  logic [CODE_W-1:0] acc_code_reg;

  logic              sample, frame_end;
  logic [ROWS-1:0]   low;
  logic [1:0]        col_hits, base_hits, tot_hits;
  logic [2:0]        hit_sum;
  logic [ROW_W-1:0]  col_row;
  logic [CODE_W-1:0] col_code, tot_code;
  kind_t             res_kind;
  logic [CODE_W-1:0] res_code;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_meta_reg <= '1;
      row_sync_reg <= '1;
    end else begin
      row_meta_reg <= bus.row;
      row_sync_reg <= row_meta_reg;
    end
  end

  assign sample    = (dwell_reg == DW_W'(SCAN_DIV - 1));
  assign frame_end = sample && (col_idx_reg == COL_W'(COLS - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dwell_reg   <= '0;
      col_idx_reg <= '0;
    end else if (sample) begin
      dwell_reg   <= '0;
      col_idx_reg <= (col_idx_reg == COL_W'(COLS - 1)) ? '0 : col_idx_reg + 1'b1;
    end else begin
      dwell_reg <= dwell_reg + 1'b1;
    end
  end

  for (genvar gi = 0; gi < COLS; gi++) begin : g_col_drive
    assign bus.shift_col[gi] = (col_idx_reg != COL_W'(gi));
  end

  // Hit counts saturate at 2: only "none / one / many" matters per frame.
  assign low = ~row_sync_reg;
  always_comb begin
    col_hits = 2'd0;
    col_row  = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (low[r]) begin
        if (col_hits == 2'd0)
          col_row = ROW_W'(r);
        if (col_hits != 2'd2)
          col_hits = col_hits + 2'd1;
      end
    end
  end

  assign col_code  = CODE_W'(col_idx_reg) * CODE_W'(ROWS) + CODE_W'(col_row);
  assign base_hits = (col_idx_reg == '0) ? 2'd0 : hits_reg;
  assign hit_sum   = {1'b0, base_hits} + {1'b0, col_hits};
  assign tot_hits  = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
  assign tot_code  = (base_hits != 2'd0) ? acc_code_reg : col_code;
  assign res_kind  = (tot_hits == 2'd0) ? NONE : (tot_hits == 2'd1) ? SINGLE : MULTI;
  assign res_code  = (tot_hits == 2'd1) ? tot_code : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hits_reg     <= '0;
      acc_code_reg <= '0;
    end else if (sample) begin
      hits_reg     <= tot_hits;
      acc_code_reg <= tot_code;
    end
  end

  kind_t             stable_kind;
  logic [CODE_W-1:0] stable_code;
  logic              stable_strobe;

  keypad_frame_debounce #(.CODE_W(CODE_W), .DEBOUNCE(DEBOUNCE)) u_debounce (
    .clk          (clk),
    .reset        (reset),
    .frame_end    (frame_end),
    .res_kind     (res_kind),
    .res_code     (res_code),
    .stable_kind  (stable_kind),
    .stable_code  (stable_code),
    .stable_strobe(stable_strobe)
  );

  state_t            state_reg, state_next;
  logic [CODE_W-1:0] key_code_reg, key_code_next;
  logic              key_valid_reg, key_valid_next;
  logic              key_release_reg, key_release_next;
  logic              same_key;

  assign same_key = (stable_kind == SINGLE) && (stable_code == key_code_reg);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg       <= IDLE;
      key_code_reg    <= '0;
      key_valid_reg   <= 1'b0;
      key_release_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      key_code_reg    <= key_code_next;
      key_valid_reg   <= key_valid_next;
      key_release_reg <= key_release_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (stable_strobe) begin
      case (state_reg)
        IDLE: begin
          if (stable_kind == SINGLE)     state_next = PRESSED;
          else if (stable_kind == MULTI) state_next = BLOCKED;
        end
        PRESSED: begin
          if (stable_kind == NONE) state_next = IDLE;
          else if (!same_key)      state_next = BLOCKED;
        end
        BLOCKED: begin
          if (stable_kind == NONE) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    key_code_next    = key_code_reg;
    key_valid_next   = 1'b0;
    key_release_next = 1'b0;
    if (stable_strobe && state_reg == IDLE && stable_kind == SINGLE) begin
      key_code_next  = stable_code;
      key_valid_next = 1'b1;
    end
    if (stable_strobe && state_reg == PRESSED && !same_key)
      key_release_next = 1'b1;
  end

  assign bus.key_code    = key_code_reg;
  assign bus.key_valid   = key_valid_reg;
  assign bus.key_release = key_release_reg;
  assign bus.key_held    = (state_reg == PRESSED);
  assign bus.multi_key   = (state_reg == BLOCKED);
endmodule
